// File: rtl/servo_pwm_gen.sv
// RC servo / ESC pulse generator on a 1 us timebase.
// Commands are shadowed and applied at frame boundaries.
module servo_pwm_gen #(
  parameter int FRAME_US   = 20000,
  parameter int MIN_US     = 1000,
  parameter int MAX_US     = 2000,
  parameter int NEUTRAL_US = 1500,
  parameter int CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_pulse_us,
  output logic             cmd_ready,
  output logic             cmd_clamped,
  output logic             frame_start,
  output logic             pwm_out
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_US);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_US);
  localparam logic [CNT_W-1:0] NEU_V  = CNT_W'(NEUTRAL_US);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(FRAME_US - 1);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  state_t           state_q;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] shadow_q;
  logic [CNT_W-1:0] active_q;
  logic             pending_q;
  logic             pwm_q;
  logic             fs_q;
  logic             clamped_q;

  logic             tick;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] shadow_d;
  logic             oor_d;

  assign tick        = sync_q[1] & ~sync_q[2];
  assign cmd_ready   = ~pending_q;
  assign accept      = cmd_valid & ~pending_q;
  assign pwm_out     = pwm_q;
  assign frame_start = fs_q;
  assign cmd_clamped = clamped_q;

  // A frame begins on a tick from IDLE or after the last LOW tick.
  assign load = enable & tick &
                ((state_q == IDLE) |
                 ((state_q == LOW) & (cnt_q == LAST_V)));

  // Clamp the incoming command into the legal pulse range.
  always_comb begin
    shadow_d = cmd_pulse_us;
    oor_d    = 1'b0;
    if (cmd_pulse_us < MIN_V) begin
      shadow_d = MIN_V;
      oor_d    = 1'b1;
    end else if (cmd_pulse_us > MAX_V) begin
      shadow_d = MAX_V;
      oor_d    = 1'b1;
    end
  end

  // Bring the divided clock in as data and keep one edge stage.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tick_in};
    end
  end

  // Frame FSM, command shadow and registered outputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= NEU_V;
      active_q  <= NEU_V;
      pending_q <= 1'b0;
      pwm_q     <= 1'b0;
      fs_q      <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      fs_q      <= 1'b0;
      clamped_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        pwm_q   <= 1'b0;
        cnt_q   <= '0;
      end else if (load) begin
        state_q   <= HIGH;
        active_q  <= shadow_q;
        pending_q <= 1'b0;
        pwm_q     <= 1'b1;
        fs_q      <= 1'b1;
        cnt_q     <= ONE_V;
      end else if (tick) begin
        unique case (state_q)
          HIGH: begin
            if (cnt_q == active_q) begin
              state_q <= LOW;
              pwm_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + ONE_V;
            end
          end
          LOW: begin
            cnt_q <= cnt_q + ONE_V;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
      if (accept) begin
        shadow_q  <= shadow_d;
        pending_q <= 1'b1;
        clamped_q <= oor_d;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: frames measured in clk cycles
// against pulse widths predicted from the command history.
module tb_servo_pwm_gen;

  localparam int FRAME = 200;
  localparam int MINV  = 10;
  localparam int MAXV  = 20;
  localparam int NEU   = 15;
  localparam int TCYC  = 4;
  localparam int PER   = FRAME * TCYC;

  logic        clk_in;
  logic        reset;
  logic        tick_in;
  logic        enable;
  logic        cmd_valid;
  logic [15:0] cmd_pulse_us;
  logic        cmd_ready;
  logic        cmd_clamped;
  logic        frame_start;
  logic        pwm_out;

  int checks;
  int errors;
  int m_shadow;
  int m_active;
  int m_pending;

  servo_pwm_gen #(
    .FRAME_US  (FRAME),
    .MIN_US    (MINV),
    .MAX_US    (MAXV),
    .NEUTRAL_US(NEU),
    .CNT_W     (16)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .tick_in     (tick_in),
    .enable      (enable),
    .cmd_valid   (cmd_valid),
    .cmd_pulse_us(cmd_pulse_us),
    .cmd_ready   (cmd_ready),
    .cmd_clamped (cmd_clamped),
    .frame_start (frame_start),
    .pwm_out     (pwm_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial tick_in = 1'b0;
  always #20 tick_in = ~tick_in;

  function automatic int clampv(input int v);
    if (v < MINV) return MINV;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  function automatic int oor(input int v);
    return (v < MINV || v > MAXV) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    while (!frame_start && n < 3 * PER) begin
      @(negedge clk_in);
      n++;
    end
    check(tag, int'(frame_start), 1);
    m_active  = m_shadow;
    m_pending = 0;
  endtask

  // Entry and exit: at the negedge of a frame_start cycle.
  task automatic run_frame(input bit send, input int val,
                           input bit late, input string tag);
    int hi;
    int cyc;
    hi  = 0;
    cyc = 0;
    check({tag, "_fs_pwm"}, int'(pwm_out), 1);
    check({tag, "_fs_ready"}, int'(cmd_ready), m_pending ? 0 : 1);
    if (send) begin
      cmd_valid    = 1'b1;
      cmd_pulse_us = 16'(val);
    end
    forever begin
      if (pwm_out) hi++;
      cyc++;
      if (late && cyc == PER) begin
        cmd_valid    = 1'b1;
        cmd_pulse_us = 16'(val);
      end
      @(negedge clk_in);
      if (send && cyc == 1) begin
        check({tag, "_clamped"}, int'(cmd_clamped), oor(val));
        check({tag, "_busy"}, int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        m_shadow  = clampv(val);
        m_pending = 1;
      end
      if (frame_start || cyc >= PER + 8) break;
    end
    check({tag, "_period"}, cyc, PER);
    check({tag, "_width"}, hi, m_active * TCYC);
    m_active = m_shadow;
    if (late) begin
      check({tag, "_late_clamped"}, int'(cmd_clamped), oor(val));
      cmd_valid = 1'b0;
      m_shadow  = clampv(val);
      m_pending = 1;
    end else begin
      m_pending = 0;
    end
  endtask

  initial begin
    int mode;
    int val;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    enable       = 1'b0;
    cmd_valid    = 1'b0;
    cmd_pulse_us = '0;
    m_shadow     = NEU;
    m_active     = NEU;
    m_pending    = 0;
    repeat (3) @(negedge clk_in);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_fs", int'(frame_start), 0);
    check("rst_clamped", int'(cmd_clamped), 0);
    reset = 1'b0;
    @(negedge clk_in);
    check("rel_ready", int'(cmd_ready), 1);
    repeat (10) @(negedge clk_in);
    check("idle_pwm", int'(pwm_out), 0);
    enable = 1'b1;
    wait_fs("first_fs");

    run_frame(0, 0, 0, "neutral_a");
    run_frame(0, 0, 0, "neutral_b");
    run_frame(1, 12, 0, "cmd12");
    run_frame(0, 0, 0, "use12");
    run_frame(1, 5, 0, "cmd5");
    run_frame(1, 30, 0, "cmd30");
    run_frame(0, 0, 0, "use30");
    run_frame(1, MINV, 0, "cmdmin");
    run_frame(1, MAXV, 0, "cmdmax");
    run_frame(1, 65535, 0, "cmdbig");
    run_frame(1, 14, 0, "cmd14");
    run_frame(0, 18, 1, "late18");
    run_frame(0, 0, 0, "old14");
    run_frame(0, 0, 0, "use18");

    for (int i = 0; i < 8; i++) begin
      mode = int'($urandom_range(0, 2));
      val  = int'($urandom_range(0, 40));
      if (m_pending != 0) mode = 0;
      run_frame(mode == 1, val, mode == 2, "rand");
    end
    run_frame(0, 0, 0, "settle");

    run_frame(1, NEU, 0, "cmd_neu");
    repeat (7 * TCYC) @(negedge clk_in);
    check("en_mid_pwm", int'(pwm_out), 1);
    enable = 1'b0;
    @(negedge clk_in);
    check("en_drop_pwm", int'(pwm_out), 0);
    repeat (25) @(negedge clk_in);
    check("en_off_pwm", int'(pwm_out), 0);
    check("en_off_fs", int'(frame_start), 0);
    enable = 1'b1;
    wait_fs("reen_fs");
    run_frame(0, 0, 0, "reen");

    run_frame(1, 11, 0, "pre_rst");
    repeat (5 * TCYC) @(negedge clk_in);
    reset = 1'b1;
    #1;
    check("rst_mid_pwm", int'(pwm_out), 0);
    @(negedge clk_in);
    reset     = 1'b0;
    m_shadow  = NEU;
    m_pending = 0;
    check("rst_ready", int'(cmd_ready), 1);
    wait_fs("post_rst_fs");
    run_frame(0, 0, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
